// File: rtl/mux1hot_stream.sv
// Round-robin N:1 stream mux with a registered single-entry output stage.
// Define MUX1HOT_STREAM_LOCK_EN to add in_last/out_last packet locking.
module mux1hot_stream #(
    parameter int INPUTS = 2,
    parameter int WIDTH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*INPUTS-1:0] in,
    input  logic [INPUTS-1:0]       in_valid,
    output logic [INPUTS-1:0]       in_ready,
`ifdef MUX1HOT_STREAM_LOCK_EN
    input  logic [INPUTS-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUTS-1:0]       grant
);

    localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    generate
        if (INPUTS < 2 || WIDTH < 1) begin : g_bad_params
            $error("mux1hot_stream: INPUTS must be >= 2 and WIDTH >= 1");
        end
    endgenerate

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [INPUTS-1:0] arb_grant;
    logic [PW-1:0]     arb_win, win;
    logic              found;
    logic [PW:0]       idx;
    logic [WIDTH-1:0]  sel;
    logic              load, xfer;
    logic [PW-1:0]     ptr_next;

    // Scan in_valid from the pointer, wrapping modulo INPUTS.
    always_comb begin
        arb_grant = '0;
        arb_win   = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < INPUTS; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(INPUTS))
                idx = idx - (PW+1)'(INPUTS);
            if (!found && in_valid[idx[PW-1:0]]) begin
                found   = 1'b1;
                arb_win = idx[PW-1:0];
            end
        end
        if (found)
            arb_grant[arb_win] = 1'b1;
    end

`ifdef MUX1HOT_STREAM_LOCK_EN
    logic          lock_q, lock_d;
    logic [PW-1:0] lock_ch_q, lock_ch_d;
    logic          out_last_q, out_last_d;
    logic          sel_last;

    // A locked packet owns the grant even while its producer is idle.
    always_comb begin
        grant = arb_grant;
        win   = arb_win;
        if (lock_q) begin
            grant            = '0;
            grant[lock_ch_q] = 1'b1;
            win              = lock_ch_q;
        end
    end
`else
    always_comb begin
        grant = arb_grant;
        win   = arb_win;
    end
`endif

    always_comb begin
        sel = '0;
        for (int i = 0; i < INPUTS; i++)
            sel = sel | (in[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end

    assign load     = ~out_valid_q | out_ready;
    assign in_ready = grant & {INPUTS{load & ~rst}};
    assign xfer     = |(in_valid & in_ready);
    assign ptr_next = (win == PW'(INPUTS-1)) ? '0 : win + 1'b1;

    always_comb begin
        out_d       = xfer ? sel : out_q;
        out_valid_d = xfer | (out_valid_q & ~out_ready);
        ptr_d       = ptr_q;
`ifdef MUX1HOT_STREAM_LOCK_EN
        sel_last   = |(in_last & grant);
        out_last_d = xfer ? sel_last : out_last_q;
        lock_d     = lock_q;
        lock_ch_d  = lock_ch_q;
        if (xfer) begin
            if (sel_last) begin
                lock_d = 1'b0;
                ptr_d  = ptr_next;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = win;
            end
        end
`else
        if (xfer)
            ptr_d = ptr_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef MUX1HOT_STREAM_LOCK_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef MUX1HOT_STREAM_LOCK_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef MUX1HOT_STREAM_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: doc/mux1hot_stream.md
Name: mux1hot_stream

Overview:
- Parametrised N-input stream multiplexer, the next generation of the one-hot mux.
- Arbitrates round-robin among valid inputs and forms a one-hot grant.
- Selects the granted payload through one-hot selection and registers it into a single-entry output stage with valid/ready handshake.
- Sits between multiple producers and one shared consumer, e.g. request merging onto a shared bus.

Parameters:
INPUTS, 2, number of input channels (>=2).
WIDTH, 1, payload width per channel in bits (>=1).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset.
in  input  WIDTH*INPUTS  packed payloads; channel i at bits [i*WIDTH +: WIDTH].
in_valid  input  INPUTS  per-channel valid.
in_ready  output  INPUTS  per-channel ready; at most one bit high.
out  output  WIDTH  registered payload.
out_valid  output  1  output stage holds data.
out_ready  input  1  consumer accepts data.
grant  output  INPUTS  one-hot current arbitration winner; all zero when no in_valid.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out=0, round-robin pointer=0 (channel 0 highest priority). In-flight beats are discarded on reset; any handshake in the reset cycle is ignored.
- Arbitration (combinational):
  - Search in_valid starting at the pointer and wrapping modulo INPUTS. The first set bit wins, so grant is exactly one-hot or zero.
  - grant never depends on out_ready (no combinational path out_ready -> grant).
- Readiness: load = ~out_valid | out_ready. in_ready[i] = grant[i] & load. Combinational path out_ready -> in_ready is permitted.
- Input transfer: occurs when in_valid[i] & in_ready[i]. On that edge:
  - out <= payload of channel i.
  - out_valid <= 1.
  - pointer <= (i+1) mod INPUTS.
- Output transfer: occurs when out_valid & out_ready.
  - If a simultaneous input transfer occurs, out is replaced and out_valid stays 1, giving full throughput of 1 beat/cycle.
  - Otherwise out_valid <= 0; out holds its last value.
- Latency: 1 cycle from input transfer to out_valid.
- Pointer: unchanged when no input transfer occurs. Wrap-around: a winner of INPUTS-1 sets the pointer to 0.
- Fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,...,INPUTS-1,0,...
- Stall: out_valid=1 & out_ready=0 drives all in_ready to 0.
  - out and out_valid hold.
  - grant may change if in_valid changes, since producers may withdraw before a handshake. The pointer does not change.
- Payload of non-granted channels never affects out.
- Invalid parameters (INPUTS<2 or WIDTH<1): elaboration-time error.

Optional Feature:
- Macro: MUX1HOT_STREAM_LOCK_EN.
- Defined:
  - Adds port in_last (input, INPUTS) and output out_last (registered alongside out, reset 0).
  - After an input transfer with in_last[i]=0, the grant is locked to channel i. The pointer and arbitration are frozen, and grant[i] stays high even if in_valid[i] drops.
  - The lock releases on the transfer with in_last[i]=1. The pointer then advances to (i+1) mod INPUTS.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports. Every beat is arbitrated independently, as above.

Test Plan:
- Reset: INPUTS=4, WIDTH=8; hold rst=1 for 2 cycles with all in_valid=1. -> out_valid=0, out=0x00, in_ready=0000 during reset; first grant after reset = 0001.
- Single channel: in_valid=0100, in[2]=0xA5, out_ready=1. -> in_ready=0100; next cycle out=0xA5, out_valid=1; pointer=3.
- Round-robin wrap: all in_valid=1111, payloads 0x10..0x13, out_ready=1 for 6 cycles. -> out sequence 0x10,0x11,0x12,0x13,0x10,0x11; grant wraps 1000 -> 0001.
- Backpressure: out_valid=1 holding 0x11, out_ready=0 for 3 cycles while in_valid=1111. -> in_ready=0000, out stays 0x11; after out_ready=1, the next beat is 0x12 in the same cycle as the 0x11 transfer (no bubble).
- Simultaneous drain/idle: out_valid=1, out_ready=1, in_valid=0000. -> out_valid=0 next cycle, pointer unchanged.
- Lock (MUX1HOT_STREAM_LOCK_EN): channel 1 sends 3 beats with in_last=0,0,1 while channel 0 stays valid. -> grant stays 0010 for all 3 beats; channel 0 granted next; out_last=1 only on the third beat.
